// File: rtl/fir_mac_seq.sv
// Time-multiplexed single-MAC FIR engine: one tap per clock against an external
// coefficient ROM with 1-cycle read latency, valid/ready on both sample streams.
module fir_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int ADDR_WIDTH = 4,
    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] s_data_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic        [ADDR_WIDTH-1:0] coef_addr_o,
    input  logic signed [COEF_WIDTH-1:0] coef_data_i,
    output logic signed [ACC_WIDTH-1:0]  m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);

    logic [1:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        k_q, k_d;
    logic [ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]        rd_ptr;
    logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
    logic signed [DATA_WIDTH-1:0] history_q [TAPS];
    logic signed [DATA_WIDTH-1:0] history_d [TAPS];
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  m_data_q, m_data_d;
    logic                         m_valid_q, m_valid_d;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc_sum;

    // sample_q lags the tap counter by one cycle, matching the ROM's registered output
    assign rd_ptr  = wr_ptr_q - k_q;
    assign prod    = PROD_WIDTH'(sample_q) * PROD_WIDTH'(coef_data_i);
    assign acc_sum = acc_q + ACC_WIDTH'(prod);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        wr_ptr_d  = wr_ptr_q;
        sample_d  = sample_q;
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        history_d = history_q;

        case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    history_d[wr_ptr_q] = s_data_i;
                    acc_d               = '0;
                    k_d                 = '0;
                    state_d             = RUN;
                end
            end
            RUN: begin
                sample_d = history_q[rd_ptr];
                if (k_q != '0) begin
                    acc_d = acc_sum;
                end
                if (k_q == LAST_TAP) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                acc_d     = acc_sum;
                m_data_d  = acc_sum;
                m_valid_d = 1'b1;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            k_q       <= '0;
            wr_ptr_q  <= '0;
            sample_q  <= '0;
            acc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                history_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wr_ptr_q  <= wr_ptr_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            history_q <= history_d;
        end
    end

    assign s_ready_o   = (state_q == IDLE);
    assign coef_addr_o = k_q;
    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;

    // A stalled output must not move until the downstream stage takes it
    assert property (@(posedge clk_i) disable iff (rst_i)
        (m_valid_q && !m_ready_i) |=> (m_valid_q && $stable(m_data_q)));

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: registered ROM model beside the DUT and a
// sliding-window convolution reference model of y[n] = sum h[k]*x[n-k].
module tb_fir_mac_seq;

    localparam int TAPS = 16;

    logic               clk;
    logic               rst;
    logic signed [15:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic        [3:0]  coef_addr;
    logic signed [15:0] coef_data;
    logic signed [35:0] m_data;
    logic               m_valid;
    logic               m_ready;

    logic signed [15:0] rom [TAPS];
    longint             hist [TAPS];

    int checks = 0;
    int passes = 0;

    fir_mac_seq dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .coef_addr_o(coef_addr),
        .coef_data_i(coef_data),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient ROM with a one-cycle registered read
    always @(posedge clk) coef_data <= rom[coef_addr];

    function automatic void ref_clear();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
    endfunction

    // Push x[n] into the window and return the full-precision convolution sum
    function automatic longint ref_push(input longint x);
        longint sum;
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += longint'(rom[k]) * hist[k];
        return sum;
    endfunction

    task automatic do_reset();
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
        @(negedge clk);
    endtask

    // Offer one sample, wait for its result; lat counts edges from accept edge (1) to m_valid
    task automatic send_sample(input logic signed [15:0] x, output longint y,
                               output int lat, output bit to);
        int guard;
        to = 1'b0; lat = 0; y = 0; guard = 0;
        s_data  = x;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (s_ready !== 1'b1) begin
            to = 1'b1;
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        while (m_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (m_valid !== 1'b1) to = 1'b1;
        y = longint'(m_data);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); else passes++;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); else passes++;
        checks++; if (m_data !== '0) $display("[TB] FAIL reset_m_data got %0d want 0", m_data); else passes++;
        checks++; if (coef_addr !== 4'd0) $display("[TB] FAIL reset_coef_addr got %0d want 0", coef_addr); else passes++;
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
        @(negedge clk);
    endtask

    task automatic test_impulse();
        longint y, want;
        int lat;
        bit to;
        for (int k = 0; k < TAPS; k++) rom[k] = 16'(k + 1);
        do_reset();
        for (int i = 0; i <= TAPS; i++) begin
            send_sample((i == 0) ? 16'sd1 : 16'sd0, y, lat, to);
            want = (i < TAPS) ? longint'(i + 1) : 0;
            checks++; if (to) $display("[TB] FAIL impulse_timeout sample %0d", i); else passes++;
            checks++; if (y != want) $display("[TB] FAIL impulse_data[%0d] got %0d want %0d", i, y, want); else passes++;
            checks++; if (lat != TAPS + 2) $display("[TB] FAIL impulse_latency[%0d] got %0d want %0d", i, lat, TAPS + 2); else passes++;
        end
    endtask

    task automatic test_wrap();
        longint y, want;
        int lat;
        bit to;
        for (int k = 0; k < TAPS; k++) rom[k] = 16'sd1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_sample(16'sd100, y, lat, to);
            want = 100 * ((i + 1 < TAPS) ? i + 1 : TAPS);
            checks++; if (to || y != want) $display("[TB] FAIL wrap_data[%0d] got %0d want %0d (timeout=%0b)", i, y, want, to); else passes++;
        end
    endtask

    task automatic test_extreme();
        longint y, want;
        int lat;
        bit to;
        for (int k = 0; k < TAPS; k++) rom[k] = -16'sd32768;
        do_reset();
        y = 0;
        for (int i = 0; i < 20; i++) begin
            send_sample(-16'sd32768, y, lat, to);
            want = ref_push(-32768);
            checks++; if (to || y != want) $display("[TB] FAIL extreme_data[%0d] got %0d want %0d", i, y, want); else passes++;
        end
        checks++; if (y != 64'sd17179869184) $display("[TB] FAIL extreme_final got %0d want 17179869184", y); else passes++;
    endtask

    task automatic test_random();
        longint y, want;
        int lat;
        bit to;
        logic signed [15:0] x;
        for (int k = 0; k < TAPS; k++) rom[k] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom);
            send_sample(x, y, lat, to);
            want = ref_push(x);
            checks++; if (to || y != want) $display("[TB] FAIL random_data[%0d] got %0d want %0d", i, y, want); else passes++;
        end
    endtask

    task automatic test_backpressure();
        longint y, want, held;
        int lat;
        bit to;
        logic signed [15:0] x1, x2;
        for (int k = 0; k < TAPS; k++) rom[k] = 16'($urandom);
        do_reset();
        m_ready = 1'b0;
        x1 = 16'($urandom);
        x2 = 16'($urandom);
        send_sample(x1, y, lat, to);
        want = ref_push(x1);
        checks++; if (to || y != want) $display("[TB] FAIL bp_first got %0d want %0d", y, want); else passes++;
        held = y;
        s_data  = x2;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (m_valid !== 1'b1) $display("[TB] FAIL bp_valid_hold[%0d] got %b want 1", i, m_valid); else passes++;
            checks++; if (longint'(m_data) != held) $display("[TB] FAIL bp_data_hold[%0d] got %0d want %0d", i, m_data, held); else passes++;
            checks++; if (s_ready !== 1'b0) $display("[TB] FAIL bp_s_ready[%0d] got %b want 0", i, s_ready); else passes++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL bp_release_valid got %b want 0", m_valid); else passes++;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", s_ready); else passes++;
        @(negedge clk);
        s_valid = 1'b0;
        want = ref_push(x2);
        lat = 1;
        while (m_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (m_valid !== 1'b1 || longint'(m_data) != want) $display("[TB] FAIL bp_held_sample got %0d want %0d", m_data, want); else passes++;
    endtask

    task automatic test_reset_mid_run();
        longint y, want;
        int lat, guard;
        bit to;
        logic signed [15:0] x;
        for (int k = 0; k < TAPS; k++) rom[k] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom);
            send_sample(x, y, lat, to);
            want = ref_push(x);
            checks++; if (to || y != want) $display("[TB] FAIL midrst_pre[%0d] got %0d want %0d", i, y, want); else passes++;
        end
        s_data = 16'($urandom);
        s_valid = 1'b1;
        guard = 0;
        while (s_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (coef_addr !== 4'd7) $display("[TB] FAIL midrst_k got %0d want 7", coef_addr); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) $display("[TB] FAIL midrst_s_ready got %b want 1", s_ready); else passes++;
        checks++; if (m_valid !== 1'b0) $display("[TB] FAIL midrst_m_valid got %b want 0", m_valid); else passes++;
        checks++; if (m_data !== '0) $display("[TB] FAIL midrst_m_data got %0d want 0", m_data); else passes++;
        checks++; if (coef_addr !== 4'd0) $display("[TB] FAIL midrst_coef_addr got %0d want 0", coef_addr); else passes++;
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_sample((i == 0) ? 16'sd1 : 16'sd0, y, lat, to);
            want = longint'(rom[i]);
            checks++; if (to || y != want) $display("[TB] FAIL midrst_impulse[%0d] got %0d want %0d", i, y, want); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        longint exp_q[$];
        longint want;
        int last_acc, accepts, d;
        bit took;
        for (int k = 0; k < TAPS; k++) rom[k] = 16'($urandom);
        do_reset();
        last_acc = -1;
        accepts = 0;
        s_data = 16'($urandom);
        s_valid = 1'b1;
        for (int cyc = 0; cyc < 115; cyc++) begin
            took = 1'b0;
            if (m_valid === 1'b1) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd0;
                checks++; if (longint'(m_data) != want) $display("[TB] FAIL b2b_data cyc %0d got %0d want %0d", cyc, m_data, want); else passes++;
            end
            d = cyc - last_acc;
            if (last_acc >= 0 && d >= 1 && d <= TAPS) begin
                checks++; if (coef_addr !== 4'(d - 1)) $display("[TB] FAIL b2b_coef_addr cyc %0d got %0d want %0d", cyc, coef_addr, d - 1); else passes++;
            end
            if (s_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++; if (d != TAPS + 3) $display("[TB] FAIL b2b_period got %0d want %0d", d, TAPS + 3); else passes++;
                end
                last_acc = cyc;
                accepts++;
                exp_q.push_back(ref_push(longint'(s_data)));
                took = 1'b1;
            end
            @(negedge clk);
            if (took) s_data = 16'($urandom);
        end
        s_valid = 1'b0;
        checks++; if (accepts != 7) $display("[TB] FAIL b2b_accepts got %0d want 7", accepts); else passes++;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            if (m_valid === 1'b1) begin
                want = exp_q.pop_front();
                checks++; if (longint'(m_data) != want) $display("[TB] FAIL b2b_tail got %0d want %0d", m_data, want); else passes++;
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("[TB] FAIL b2b_outstanding got %0d want 0", exp_q.size()); else passes++;
    endtask

    initial begin
        for (int k = 0; k < TAPS; k++) rom[k] = '0;
        ref_clear();
        test_reset();
        test_impulse();
        test_wrap();
        test_extreme();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
